oam_dma: RTL and testbench

//  Sprite-OAM writer: the fill side of the 256-byte OAM that the PPU reads through oama/oamd.
//  A CPU write to $4014 copies one 256-byte PRG page ($XX00-$XXFF) into OAM.

---
 rtl/dendy_pkg.sv | 17 +
 rtl/oam_dma.sv | 102 ++++++++++
 tb/tb_oam_dma.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dendy_pkg.sv
// Shared definitions for the Dendy/NES-style video/CPU glue blocks.
// Holds the OAM DMA trigger address, its FSM state set and the CPU bus address type.
package dendy_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    typedef logic [15:0] bus_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        DUMMY,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to DMA_REG copies one 256-byte PRG page into OAM,
// owning the PRG bus and stalling the CPU for 513/514 CPU cycles.
module oam_dma
    import dendy_pkg::*;
#(
    parameter bus_addr_t DMA_REG  = DMA_REG_ADDR,
    parameter bit        ALIGN_EN = 1'b1
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_w,
    input  logic [7:0]  oam_base,
    output logic [15:0] prga,
    input  logic [7:0]  prgi,
    output logic        dma_busy,
    output logic [7:0]  oam_wa,
    output logic [7:0]  oam_wd,
    output logic        oam_we,
    output logic        dma_done
);

    dma_state_t r_state;
    dma_state_t w_state_next;

    logic       r_parity;
    logic [7:0] r_page;
    logic [7:0] r_ptr;
    logic [7:0] r_count;
    logic [7:0] r_data;
    logic       r_cap;
    logic       r_done;

    logic       w_trigger;
    logic       w_write;
    logic [7:0] w_wdata;

    assign w_trigger = ce_cpu && cpu_w && (cpu_a == DMA_REG) && (r_state == IDLE);
    assign w_write   = ce_cpu && (r_state == WRITE);

    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        if (ce_cpu) begin
            case (r_state)
                IDLE:    if (w_trigger) w_state_next = DUMMY;
                DUMMY:   w_state_next = (ALIGN_EN && r_parity) ? ALIGN : READ;
                ALIGN:   w_state_next = READ;
                READ:    w_state_next = WRITE;
                WRITE:   w_state_next = (r_count == 8'hFF) ? IDLE : READ;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
            r_page   <= 8'h00;
            r_ptr    <= 8'h00;
            r_count  <= 8'h00;
            r_data   <= 8'h00;
            r_cap    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // prgi is only valid one clock after the READ tick, regardless of ce_cpu.
            r_cap  <= ce_cpu && (r_state == READ);
            r_done <= w_write && (r_count == 8'hFF);
            if (r_cap) r_data <= prgi;
            if (ce_cpu) begin
                r_parity <= ~r_parity;
                if (w_trigger) begin
                    r_page  <= cpu_o;
                    r_ptr   <= oam_base;
                    r_count <= 8'h00;
                end else if (r_state == WRITE) begin
                    r_ptr   <= r_ptr + 8'd1;
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    // When the WRITE tick immediately follows READ, the byte is still on prgi, not in r_data.
    assign w_wdata  = r_cap ? prgi : r_data;

    assign dma_busy = (r_state != IDLE);
    assign prga     = dma_busy ? {r_page, r_count} : 16'h0000;
    assign oam_we   = w_write;
    assign oam_wa   = w_write ? r_ptr : 8'h00;
    assign oam_wd   = w_write ? w_wdata : 8'h00;
    assign dma_done = r_done;

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: two instances (ALIGN_EN=1 and 0) share stimulus; a PRG/OAM
// model and a stall/write-count model derived from the cycle budget check each transfer.
module tb_oam_dma;
    import dendy_pkg::*;

    logic        clock25  = 1'b0;
    logic        reset    = 1'b1;
    logic        ce_cpu   = 1'b0;
    logic        cpu_w    = 1'b0;
    logic [15:0] cpu_a    = 16'h0000;
    logic [7:0]  cpu_o    = 8'h00;
    logic [7:0]  oam_base = 8'h00;

    logic [15:0] prga, prga2;
    logic [7:0]  prgi = 8'h00, prgi2 = 8'h00;
    logic        dma_busy, busy2;
    logic [7:0]  oam_wa, oam_wa2, oam_wd, oam_wd2;
    logic        oam_we, oam_we2, dma_done, done2;

    always #5 clock25 = ~clock25;

    oam_dma #(.ALIGN_EN(1'b1)) dut (
        .clock25(clock25), .reset(reset), .ce_cpu(ce_cpu), .cpu_a(cpu_a), .cpu_o(cpu_o),
        .cpu_w(cpu_w), .oam_base(oam_base), .prga(prga), .prgi(prgi), .dma_busy(dma_busy),
        .oam_wa(oam_wa), .oam_wd(oam_wd), .oam_we(oam_we), .dma_done(dma_done)
    );

    oam_dma #(.ALIGN_EN(1'b0)) dut_na (
        .clock25(clock25), .reset(reset), .ce_cpu(ce_cpu), .cpu_a(cpu_a), .cpu_o(cpu_o),
        .cpu_w(cpu_w), .oam_base(oam_base), .prga(prga2), .prgi(prgi2), .dma_busy(busy2),
        .oam_wa(oam_wa2), .oam_wd(oam_wd2), .oam_we(oam_we2), .dma_done(done2)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] oam     [0:255];
    logic [7:0] oam_exp [0:255];

    int   n_tests = 0, n_fail = 0;
    int   ticks = 0, ticks2 = 0, we_cnt = 0, done_cnt = 0, done_cnt2 = 0, par_cnt = 0;
    logic fill_req = 1'b0;

    // Synchronous PRG ROM/RAM: data for an address appears one clock later.
    always @(posedge clock25) begin
        prgi  <= mem[prga];
        prgi2 <= mem[prga2];
    end

    // Observers sample mid-cycle; a value seen here is what the next posedge will act on.
    always @(negedge clock25) begin
        if (fill_req)
            for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
        if (reset) begin
            par_cnt = 0;
        end else begin
            if (ce_cpu) begin
                par_cnt++;
                if (dma_busy) ticks++;
                if (busy2)    ticks2++;
            end
            if (oam_we) begin
                oam[oam_wa] = oam_wd;
                we_cnt++;
            end
            if (dma_done) done_cnt++;
            if (done2)    done_cnt2++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oam_diff();
        int d = 0;
        for (int i = 0; i < 256; i++)
            if (oam[i] !== oam_exp[i]) d++;
        return d;
    endfunction

    // Reference: the first n bytes of the page land at base, base+1, ... modulo 256.
    task automatic model_fill(input logic [7:0] page, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] off;
            logic [7:0] idx;
            off = 8'(i);
            idx = base + off;
            oam_exp[idx] = mem[{page, off}];
        end
    endtask

    task automatic step(input bit ce, input bit w, input logic [15:0] a, input logic [7:0] d);
        ce_cpu = ce;
        cpu_w  = w;
        cpu_a  = a;
        cpu_o  = d;
        @(posedge clock25);
        #1;
    endtask

    // dpar selects the CPU parity seen at the DUMMY tick (the tick after the trigger).
    task automatic run_dma(input logic [7:0] page, input logic [7:0] base, input bit dpar,
                           input bit gappy, input int second_at, input int reset_at,
                           output int t1, output int t2, output int nwe,
                           output int nd, output int nd2);
        int s1, s2, sw, sd, sd2, guard;
        bit ce, w;
        sd  = done_cnt  + int'(dma_done);
        sd2 = done_cnt2 + int'(done2);
        if (par_cnt[0] == dpar) step(1'b1, 1'b0, 16'h0000, 8'h00);
        s1 = ticks;
        s2 = ticks2;
        sw = we_cnt;
        oam_base = base;
        step(1'b1, 1'b1, DMA_REG_ADDR, page);
        guard = 0;
        while ((dma_busy || busy2) && guard < 5000) begin
            if (reset_at > 0 && ticks - s1 == reset_at - 1) begin
                reset  = 1'b1;
                ce_cpu = 1'b0;
                cpu_w  = 1'b0;
                #1;
                check("rst_mid_busy", dma_busy, 0);
                check("rst_mid_prga", prga, 0);
                check("rst_mid_we",   oam_we, 0);
                check("rst_mid_wa",   oam_wa, 0);
                check("rst_mid_wd",   oam_wd, 0);
                check("rst_mid_done", dma_done, 0);
                repeat (2) @(posedge clock25);
                #1;
                reset = 1'b0;
                break;
            end
            ce = gappy ? ($urandom_range(0, 2) == 0) : 1'b1;
            w  = (second_at > 0) && ce && (ticks - s1 == second_at - 1);
            if (w) step(ce, 1'b1, DMA_REG_ADDR, 8'h07);
            else   step(ce, ce && ($urandom_range(0, 3) == 0), 16'h4015, 8'($urandom));
            guard++;
        end
        check("timeout", guard < 5000, 1);
        t1  = ticks - s1;
        t2  = ticks2 - s2;
        nwe = we_cnt - sw;
        nd  = done_cnt  - sd  + int'(dma_done);
        nd2 = done_cnt2 - sd2 + int'(done2);
    endtask

    initial begin
        int t1, t2, nwe, nd, nd2, n_part;
        bit dp;
        logic [7:0] pg, bs;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 256; i++) oam_exp[i] = 8'hEE;
        fill_req = 1'b1;
        @(negedge clock25);
        fill_req = 1'b0;

        repeat (3) @(posedge clock25);
        #1;
        check("reset_busy", dma_busy, 0);
        check("reset_prga", prga, 0);
        check("reset_we",   oam_we, 0);
        check("reset_wa",   oam_wa, 0);
        check("reset_wd",   oam_wd, 0);
        check("reset_done", dma_done, 0);
        check("reset_busy_na", busy2, 0);
        reset = 1'b0;

        // Even trigger, page $02, base 0.
        run_dma(8'h02, 8'h00, 1'b0, 1'b0, 0, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'h02, 8'h00, 256);
        check("even_ticks", t1, 513);
        check("even_ticks_na", t2, 513);
        check("even_writes", nwe, 256);
        check("even_done", nd, 1);
        check("even_done_na", nd2, 1);
        check("even_oam", oam_diff(), 0);

        // Odd trigger: alignment tick only with ALIGN_EN.
        run_dma(8'h02, 8'h00, 1'b1, 1'b0, 0, 0, t1, t2, nwe, nd, nd2);
        check("odd_ticks", t1, 514);
        check("odd_ticks_na", t2, 513);
        check("odd_done", nd, 1);
        check("odd_oam", oam_diff(), 0);

        // OAM pointer wrap from base $F0.
        dp = 1'($urandom_range(0, 1));
        run_dma(8'h03, 8'hF0, dp, 1'b0, 0, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'h03, 8'hF0, 256);
        check("wrap_ticks", t1, 513 + int'(dp));
        check("wrap_f0", oam[8'hF0], mem[16'h0300]);
        check("wrap_ff", oam[8'hFF], mem[16'h030F]);
        check("wrap_00", oam[8'h00], mem[16'h0310]);
        check("wrap_oam", oam_diff(), 0);

        // Retrigger (page $07) at tick 100 is ignored.
        run_dma(8'h02, 8'h40, 1'b0, 1'b0, 100, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'h02, 8'h40, 256);
        check("retrig_ticks", t1, 513);
        check("retrig_ticks_na", t2, 513);
        check("retrig_writes", nwe, 256);
        check("retrig_done", nd, 1);
        check("retrig_oam", oam_diff(), 0);

        // Reset before tick 300: DUMMY + 149 READ/WRITE pairs have completed.
        run_dma(8'h11, 8'h00, 1'b0, 1'b0, 0, 300, t1, t2, nwe, nd, nd2);
        n_part = (299 - 1 - 0) / 2;
        model_fill(8'h11, 8'h00, n_part);
        check("abort_writes", nwe, n_part);
        check("abort_last", oam[8'd148], mem[16'h1194]);
        check("abort_untouched", oam[8'd149], oam_exp[8'd149]);
        check("abort_oam", oam_diff(), 0);

        // Fresh transfer after reset, top page $FF.
        run_dma(8'hFF, 8'h80, 1'b0, 1'b0, 0, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'hFF, 8'h80, 256);
        check("post_rst_ticks", t1, 513);
        check("post_rst_writes", nwe, 256);
        check("post_rst_oam", oam_diff(), 0);

        // Gappy ce_cpu at ~1/3 duty.
        run_dma(8'h02, 8'h00, 1'b0, 1'b1, 0, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'h02, 8'h00, 256);
        check("gap_ticks", t1, 513);
        check("gap_writes", nwe, 256);
        check("gap_done", nd, 1);
        check("gap_oam", oam_diff(), 0);

        // Back-to-back: trigger on the very next ce tick after completion.
        dp = ~par_cnt[0];
        run_dma(8'h05, 8'h20, dp, 1'b0, 0, 0, t1, t2, nwe, nd, nd2);
        model_fill(8'h05, 8'h20, 256);
        check("b2b_ticks", t1, 513 + int'(dp));
        check("b2b_ticks_na", t2, 513);
        check("b2b_done", nd, 1);
        check("b2b_oam", oam_diff(), 0);

        for (int r = 0; r < 4; r++) begin
            int sec;
            bit gap;
            pg  = 8'($urandom);
            bs  = 8'($urandom);
            dp  = 1'($urandom_range(0, 1));
            gap = 1'($urandom_range(0, 1));
            sec = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 500)) : 0;
            run_dma(pg, bs, dp, gap, sec, 0, t1, t2, nwe, nd, nd2);
            model_fill(pg, bs, 256);
            check("rand_ticks", t1, 513 + int'(dp));
            check("rand_ticks_na", t2, 513);
            check("rand_writes", nwe, 256);
            check("rand_done", nd, 1);
            check("rand_done_na", nd2, 1);
            check("rand_oam", oam_diff(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
